// File: rtl/ast_frame_arbiter_if.sv
// Avalon-ST beat bundle: data plus sop/eop qualifiers with a ready-latency-0 handshake.
interface ast_frame_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  startofpacket;
  logic                  endofpacket;
  logic                  ready;

  // Stream producer.
  modport master (
    output data,
    output valid,
    output startofpacket,
    output endofpacket,
    input  ready
  );

  // Stream consumer.
  modport slave (
    input  data,
    input  valid,
    input  startofpacket,
    input  endofpacket,
    output ready
  );
endinterface

// File: rtl/ast_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one Avalon-ST video sink between two sources.
// A frame is any run of packets closed by a video (type 0x0) packet, so control packets stay
// glued to their video packet. Disabled sources can be flushed; frame and drop counts are kept.
module ast_frame_arbiter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  ast_frame_arbiter_if.slave         in0,
  ast_frame_arbiter_if.slave         in1,
  ast_frame_arbiter_if.master        dout,
  input  logic [1:0]                 src_enable,
  input  logic                       flush_disabled,
  output logic [1:0]                 active_src,
  output logic [15:0]                frame_count0,
  output logic [15:0]                frame_count1,
  output logic [15:0]                drop_count
);

  typedef enum logic [0:0] {StIdle, StPass} state_e;

  state_e                state_q, state_d;
  logic                  src_q, src_d;
  logic                  last_q, last_d;
  logic [3:0]            ptype_q, ptype_d;
  logic [DATA_WIDTH-1:0] dout_data_q, dout_data_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  dout_sop_q, dout_sop_d;
  logic                  dout_eop_q, dout_eop_d;
  logic [15:0]           fc0_q, fc0_d;
  logic [15:0]           fc1_q, fc1_d;
  logic [15:0]           drop_q, drop_d;

  logic [1:0]            in_valid, in_sop, in_eop, in_ready;
  logic [DATA_WIDTH-1:0] in_data [2];
  logic [1:0]            eligible, accept, drop, granted_mask;
  logic                  out_free, fwd, pref;
  logic [3:0]            beat_type;
  logic [16:0]           drop_sum;

  assign in_valid   = {in1.valid, in0.valid};
  assign in_sop     = {in1.startofpacket, in0.startofpacket};
  assign in_eop     = {in1.endofpacket, in0.endofpacket};
  assign in_data[0] = in0.data;
  assign in_data[1] = in1.data;
  assign in0.ready  = in_ready[0];
  assign in1.ready  = in_ready[1];

  assign dout.data          = dout_data_q;
  assign dout.valid         = dout_valid_q;
  assign dout.startofpacket = dout_sop_q;
  assign dout.endofpacket   = dout_eop_q;

  assign frame_count0 = fc0_q;
  assign frame_count1 = fc1_q;
  assign drop_count   = drop_q;

  assign granted_mask = (state_q == StPass) ? (src_q ? 2'b10 : 2'b01) : 2'b00;
  assign active_src   = granted_mask;

  // Output register can take a beat when empty or draining this cycle.
  assign out_free = ~dout_valid_q | dout.ready;
  assign eligible = src_enable & in_valid & in_sop;
  assign pref     = ~last_q;

  // Ready generation: flush, desync recovery in IDLE, or pass-through for the granted source.
  // Ready never looks at in*_valid.
  always_comb begin
    in_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (!src_enable[i] && flush_disabled && !granted_mask[i]) begin
        in_ready[i] = 1'b1;
      end else if (state_q == StIdle && src_enable[i] && !in_sop[i]) begin
        in_ready[i] = 1'b1;
      end else if (granted_mask[i]) begin
        in_ready[i] = out_free;
      end
    end
    if (reset) in_ready = 2'b00;
  end

  assign accept    = in_valid & in_ready;
  assign fwd       = (state_q == StPass) && accept[src_q];
  assign drop      = accept & ~granted_mask;
  // The sop beat itself defines the type when it is also the eop.
  assign beat_type = in_sop[src_q] ? in_data[src_q][3:0] : ptype_q;

  // Arbitration, pass-through and frame accounting.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    last_d       = last_q;
    ptype_d      = ptype_q;
    dout_data_d  = dout_data_q;
    dout_valid_d = dout_valid_q;
    dout_sop_d   = dout_sop_q;
    dout_eop_d   = dout_eop_q;
    fc0_d        = fc0_q;
    fc1_d        = fc1_q;

    unique case (state_q)
      StIdle: begin
        if (eligible[pref]) begin
          src_d   = pref;
          last_d  = pref;
          state_d = StPass;
        end else if (eligible[last_q]) begin
          src_d   = last_q;
          last_d  = last_q;
          state_d = StPass;
        end
      end
      StPass: begin
        if (fwd) begin
          if (in_sop[src_q]) ptype_d = in_data[src_q][3:0];
          if (in_eop[src_q] && beat_type == 4'h0) begin
            state_d = StIdle;
            if (src_q) fc1_d = fc1_q + 16'd1;
            else       fc0_d = fc0_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (fwd) begin
      dout_data_d  = in_data[src_q];
      dout_valid_d = 1'b1;
      dout_sop_d   = in_sop[src_q];
      dout_eop_d   = in_eop[src_q];
    end else if (dout.ready) begin
      dout_valid_d = 1'b0;
    end
  end

  // Saturating drop counter; both sources may drop in the same cycle.
  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(drop[0]) + 17'(drop[1]);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      src_q        <= 1'b0;
      last_q       <= 1'b1;
      ptype_q      <= 4'h0;
      dout_data_q  <= '0;
      dout_valid_q <= 1'b0;
      dout_sop_q   <= 1'b0;
      dout_eop_q   <= 1'b0;
      fc0_q        <= 16'd0;
      fc1_q        <= 16'd0;
      drop_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      last_q       <= last_d;
      ptype_q      <= ptype_d;
      dout_data_q  <= dout_data_d;
      dout_valid_q <= dout_valid_d;
      dout_sop_q   <= dout_sop_d;
      dout_eop_q   <= dout_eop_d;
      fc0_q        <= fc0_d;
      fc1_q        <= fc1_d;
      drop_q       <= drop_d;
    end
  end

endmodule

// File: tb/tb_ast_frame_arbiter.sv
// Bench for ast_frame_arbiter: queue-based sources, expected output order built frame by frame.
module tb_ast_frame_arbiter;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  src_enable = 2'b00;
  logic        flush_disabled = 1'b0;
  logic [1:0]  active_src;
  logic [15:0] frame_count0, frame_count1, drop_count;

  ast_frame_arbiter_if #(.DATA_WIDTH(8)) in0_if ();
  ast_frame_arbiter_if #(.DATA_WIDTH(8)) in1_if ();
  ast_frame_arbiter_if #(.DATA_WIDTH(8)) dout_if ();

  ast_frame_arbiter #(.DATA_WIDTH(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .in0            (in0_if),
    .in1            (in1_if),
    .dout           (dout_if),
    .src_enable     (src_enable),
    .flush_disabled (flush_disabled),
    .active_src     (active_src),
    .frame_count0   (frame_count0),
    .frame_count1   (frame_count1),
    .drop_count     (drop_count)
  );

  always #5 clock = ~clock;

  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  beat_t q0[$], q1[$], exp_q[$];
  int    lat_q[$];
  bit    drv0 = 0, drv1 = 0, lat_chk = 0;
  int    rdy_mode = 0;        // 0: always ready, 1: toggle, 2: random
  int    flush_rdy_chk = -1;  // expected in1 ready while in1 valid, -1 = unchecked
  bit    hold_prev = 0;
  beat_t out_prev;
  int    first_acc, last_acc, acc_total;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_src(input int src, input beat_t b, input bit to_exp);
    if (src == 0) q0.push_back(b);
    else          q1.push_back(b);
    if (to_exp) exp_q.push_back(b);
  endtask

  // Frame = optional control packet (type 0xF) followed by one video packet (type 0x0).
  task automatic add_frame(input int src, input int nctrl, input int nvid);
    beat_t b;
    for (int k = 0; k < nctrl; k++) begin
      b.d   = (k == 0) ? {4'($urandom_range(0, 15)), 4'hF} : 8'($urandom_range(0, 255));
      b.sop = (k == 0);
      b.eop = (k == nctrl - 1);
      push_src(src, b, 1'b1);
    end
    for (int k = 0; k < nvid; k++) begin
      b.d   = (k == 0) ? {4'($urandom_range(0, 15)), 4'h0} : 8'($urandom_range(0, 255));
      b.sop = (k == 0);
      b.eop = (k == nvid - 1);
      push_src(src, b, 1'b1);
    end
  endtask

  task automatic push_junk(input int src, input int n, input bit rand_flags);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d   = 8'($urandom_range(0, 255));
      b.sop = rand_flags ? 1'($urandom_range(0, 1)) : 1'b0;
      b.eop = rand_flags ? 1'($urandom_range(0, 1)) : 1'b0;
      push_src(src, b, 1'b0);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 time unit before posedge.
  task automatic tick();
    beat_t ob;
    logic  a0, a1;
    if (drv0 && q0.size() > 0) begin
      in0_if.valid = 1'b1; in0_if.data = q0[0].d;
      in0_if.startofpacket = q0[0].sop; in0_if.endofpacket = q0[0].eop;
    end else begin
      in0_if.valid = 1'b0; in0_if.data = '0;
      in0_if.startofpacket = 1'b0; in0_if.endofpacket = 1'b0;
    end
    if (drv1 && q1.size() > 0) begin
      in1_if.valid = 1'b1; in1_if.data = q1[0].d;
      in1_if.startofpacket = q1[0].sop; in1_if.endofpacket = q1[0].eop;
    end else begin
      in1_if.valid = 1'b0; in1_if.data = '0;
      in1_if.startofpacket = 1'b0; in1_if.endofpacket = 1'b0;
    end
    case (rdy_mode)
      0:       dout_if.ready = 1'b1;
      1:       dout_if.ready = (cyc % 2 == 0);
      default: dout_if.ready = 1'($urandom_range(0, 1));
    endcase
    #4;
    ob = {dout_if.data, dout_if.startofpacket, dout_if.endofpacket};
    if (hold_prev) check_eq("hold", {dout_if.valid, ob}, {1'b1, out_prev});
    if (flush_rdy_chk >= 0 && in1_if.valid) check_eq("in1_ready", in1_if.ready, flush_rdy_chk);
    a0 = in0_if.valid & in0_if.ready;
    a1 = in1_if.valid & in1_if.ready;
    if (a0) begin
      void'(q0.pop_front());
      if (lat_chk) begin
        lat_q.push_back(cyc);
        check_eq("active_src_pass", active_src, 2'b01);
      end
    end
    if (a1) void'(q1.pop_front());
    if (a0 || a1) begin
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      acc_total++;
    end
    if (dout_if.valid && dout_if.ready) begin
      check_eq("exp_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_eq("dout_beat", ob, exp_q.pop_front());
      if (lat_chk && lat_q.size() > 0) check_eq("latency", cyc, lat_q.pop_front() + 1);
    end
    hold_prev = dout_if.valid & ~dout_if.ready;
    out_prev  = ob;
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic run_until_done(input int max_cyc, input bit wait_q1);
    int n = 0;
    while ((q0.size() > 0 || (wait_q1 && q1.size() > 0) || exp_q.size() > 0) && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq("drain_left", q0.size() + exp_q.size() + (wait_q1 ? q1.size() : 0), 0);
  endtask

  task automatic do_reset();
    drv0 = 0; drv1 = 0; hold_prev = 0;
    q0.delete(); q1.delete(); exp_q.delete(); lat_q.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hold_prev = 0;
    first_acc = -1; last_acc = 0; acc_total = 0;
  endtask

  task automatic rr_frames(input int nf, input int maxv);
    for (int f = 0; f < nf; f++) begin
      add_frame(0, $urandom_range(0, 3), $urandom_range(1, maxv));
      add_frame(1, $urandom_range(0, 3), $urandom_range(1, maxv));
    end
  endtask

  initial begin
    int nbeats;
    in0_if.valid = 0; in0_if.data = '0; in0_if.startofpacket = 0; in0_if.endofpacket = 0;
    in1_if.valid = 0; in1_if.data = '0; in1_if.startofpacket = 0; in1_if.endofpacket = 0;
    dout_if.ready = 1'b1;
    @(negedge clock);

    // Reset state: enabled idle sources without sop would be ready, but reset forces 0.
    src_enable = 2'b11;
    reset = 1'b1;
    do_reset();
    reset = 1'b1;
    in1_if.valid = 1'b1;
    #1;
    check_eq("rst_in0_ready", in0_if.ready, 0);
    check_eq("rst_in1_ready", in1_if.ready, 0);
    check_eq("rst_dout", {dout_if.valid, dout_if.startofpacket, dout_if.endofpacket, dout_if.data}, 0);
    check_eq("rst_counts", {frame_count0, frame_count1}, 0);
    check_eq("rst_drop", drop_count, 0);
    check_eq("rst_active", active_src, 0);
    in1_if.valid = 1'b0;
    reset = 1'b0;

    // Single source: control + 640-beat video, 1-cycle latency, active_src returns to 00.
    do_reset();
    src_enable = 2'b01; drv0 = 1; rdy_mode = 0; lat_chk = 1;
    add_frame(0, 10, 640);
    run_until_done(2000, 0);
    lat_chk = 0;
    check_eq("t1_fc0", frame_count0, 1);
    check_eq("t1_fc1", frame_count1, 0);
    check_eq("t1_active", active_src, 0);
    check_eq("t1_drop", drop_count, 0);

    // Both sources busy: alternate 0,1,0,1 with one bubble per frame boundary.
    do_reset();
    src_enable = 2'b11; drv0 = 1; drv1 = 1; rdy_mode = 0;
    rr_frames(4, 6);
    nbeats = q0.size() + q1.size();
    run_until_done(2000, 1);
    check_eq("t2_span", last_acc - first_acc + 1, nbeats + 8 - 1);
    check_eq("t2_acc", acc_total, nbeats);
    check_eq("t2_fc", {frame_count0, frame_count1}, {16'd4, 16'd4});

    // Backpressure toggling on a single-source frame, then random backpressure with both.
    do_reset();
    src_enable = 2'b01; drv0 = 1; rdy_mode = 1;
    add_frame(0, 2, 40);
    run_until_done(500, 0);
    check_eq("t3_fc0", frame_count0, 1);
    do_reset();
    src_enable = 2'b11; drv0 = 1; drv1 = 1; rdy_mode = 2;
    rr_frames(6, 12);
    run_until_done(3000, 1);
    check_eq("t3r_fc", {frame_count0, frame_count1}, {16'd6, 16'd6});
    check_eq("t3r_drop", drop_count, 0);

    // Desync recovery: 5 sop-less beats on in1 are dropped, its next sop is granted.
    do_reset();
    src_enable = 2'b11; drv1 = 1; rdy_mode = 0;
    push_junk(1, 5, 0);
    add_frame(1, 0, 4);
    run_until_done(200, 1);
    check_eq("t4_drop", drop_count, 5);
    check_eq("t4_fc1", frame_count1, 1);
    // Simultaneous drops from both sources count twice per cycle.
    do_reset();
    src_enable = 2'b11; drv0 = 1; drv1 = 1;
    push_junk(0, 3, 0);
    push_junk(1, 3, 0);
    run_until_done(50, 1);
    check_eq("t4_drop2", drop_count, 6);

    // Flush of disabled in1 during an in0 frame.
    do_reset();
    src_enable = 2'b01; flush_disabled = 1; drv0 = 1; drv1 = 1; rdy_mode = 0;
    add_frame(0, 0, 120);
    push_junk(1, 100, 1);
    flush_rdy_chk = 1;
    run_until_done(500, 1);
    flush_rdy_chk = -1;
    check_eq("t5_drop", drop_count, 100);
    check_eq("t5_fc0", frame_count0, 1);
    do_reset();
    src_enable = 2'b01; flush_disabled = 0; drv0 = 1; drv1 = 1;
    add_frame(0, 0, 20);
    push_junk(1, 10, 1);
    flush_rdy_chk = 0;
    run_until_done(200, 0);
    flush_rdy_chk = -1;
    check_eq("t5n_drop", drop_count, 0);
    check_eq("t5n_left", q1.size(), 10);

    // Reset mid-video-packet: everything clears, next grant goes to source 0.
    do_reset();
    src_enable = 2'b01; drv0 = 1; rdy_mode = 0;
    add_frame(0, 0, 50);
    repeat (20) tick();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_ready", in0_if.ready, 0);
    tick();
    reset = 1'b0;
    hold_prev = 0;
    check_eq("mid_rst_dout", {dout_if.valid, dout_if.startofpacket, dout_if.endofpacket, dout_if.data}, 0);
    check_eq("mid_rst_active", active_src, 0);
    check_eq("mid_rst_counts", {frame_count0, frame_count1, drop_count}, 0);
    q0.delete(); exp_q.delete();
    src_enable = 2'b11; drv0 = 1; drv1 = 1;
    add_frame(0, 1, 3);
    add_frame(1, 1, 3);
    run_until_done(100, 1);
    check_eq("post_rst_fc", {frame_count0, frame_count1}, {16'd1, 16'd1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
